// File: rtl/line_window3.sv
// line_window3: three-row vertical window (rows y-2, y-1, y) over a raster pixel stream.
// Define LINE_WINDOW3_BORDER_REPLICATE_EN to emit replicated top-border rows 0 and 1.
module line_window3 #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 640,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sof,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] doutA,
    output logic [DATA_WIDTH-1:0] doutB,
    output logic [DATA_WIDTH-1:0] doutC,
    output logic                  dout_last
);

    localparam logic [CNT_WIDTH-1:0] LAST_COL = CNT_WIDTH'(LINE_LEN - 1);

    logic [DATA_WIDTH-1:0] lb_a [LINE_LEN];
    logic [DATA_WIDTH-1:0] lb_b [LINE_LEN];

    logic [CNT_WIDTH-1:0]  col;
    logic [CNT_WIDTH-1:0]  col_eff;
    logic [CNT_WIDTH-1:0]  col_nxt;
    logic [1:0]            row;
    logic [1:0]            row_eff;
    logic [1:0]            row_nxt;
    logic                  sof_q;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] nxt_a;
    logic [DATA_WIDTH-1:0] nxt_b;
    logic                  nxt_valid;

    // sof restarts the frame on the very pixel it accompanies
    assign sof_q   = din_valid & sof;
    assign col_eff = sof_q ? '0 : col;
    assign row_eff = sof_q ? '0 : row;
    assign at_last = (col_eff == LAST_COL);
    assign col_nxt = at_last ? '0 : col_eff + 1'b1;
    assign row_nxt = (at_last && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;

    assign rd_a = lb_a[col_eff];
    assign rd_b = lb_b[col_eff];

    // cascade shift: both reads see the contents from before this write
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb_a[col_eff] <= rd_b;
            lb_b[col_eff] <= din;
        end
    end

`ifdef LINE_WINDOW3_BORDER_REPLICATE_EN
    always_comb begin
        nxt_valid = 1'b1;
        nxt_a     = rd_a;
        nxt_b     = rd_b;
        unique case (1'b1)
            row_eff == 2'd0: begin
                nxt_a = din;
                nxt_b = din;
            end
            row_eff == 2'd1: begin
                nxt_a = rd_b;
            end
            default: begin
            end
        endcase
    end
`else
    always_comb begin
        nxt_valid = (row_eff == 2'd2);
        nxt_a     = rd_a;
        nxt_b     = rd_b;
    end
`endif

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            doutA      <= '0;
            doutB      <= '0;
            doutC      <= '0;
        end else begin
            dout_valid <= din_valid & nxt_valid;
            dout_last  <= din_valid & at_last;
            if (din_valid) begin
                doutA <= nxt_a;
                doutB <= nxt_b;
                doutC <= din;
            end
        end
    end

endmodule

// File: tb/tb_line_window3.sv
// tb_line_window3: directed scoreboard bench for line_window3 (LINE_LEN=4).
// Expected beats are derived from a per-frame pixel history, not from the DUT.
module tb_line_window3;

    localparam int DW = 8;
    localparam int LL = 4;
    localparam int CW = 2;
`ifdef LINE_WINDOW3_BORDER_REPLICATE_EN
    localparam int FRAME_BEATS = 16;
`else
    localparam int FRAME_BEATS = 8;
`endif

    logic          clk = 1'b0;
    logic          arstn = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          sof = 1'b0;
    logic          dout_valid;
    logic [DW-1:0] doutA;
    logic [DW-1:0] doutB;
    logic [DW-1:0] doutC;
    logic          dout_last;

    line_window3 #(
        .DATA_WIDTH(DW),
        .LINE_LEN  (LL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .din_valid (din_valid),
        .din       (din),
        .sof       (sof),
        .dout_valid(dout_valid),
        .doutA     (doutA),
        .doutB     (doutB),
        .doutC     (doutC),
        .dout_last (dout_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          last;
        logic          ka;
        logic          kb;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
    } beat_t;

    beat_t         sb[$];
    beat_t         hold;
    int            checks = 0;
    int            errors = 0;
    int            beats  = 0;
    int            brow   = 0;
    int            bcol   = 0;
    logic [DW-1:0] hist [0:15][0:LL-1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic clear_model();
        brow        = 0;
        bcol        = 0;
        hold.v      = 1'b0;
        hold.last   = 1'b0;
        hold.ka     = 1'b1;
        hold.kb     = 1'b1;
        hold.a      = '0;
        hold.b      = '0;
        hold.c      = '0;
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
        beat_t e;
        beat_t g;
        int    r;
        int    c;
        e      = hold;
        e.v    = 1'b0;
        e.last = 1'b0;
        if (v) begin
            if (s) begin
                brow = 0;
                bcol = 0;
            end
            r          = brow;
            c          = bcol;
            hist[r][c] = d;
            e.c        = d;
            e.last     = (c == LL - 1);
            e.ka       = 1'b1;
            e.kb       = 1'b1;
`ifdef LINE_WINDOW3_BORDER_REPLICATE_EN
            e.v = 1'b1;
            if (r == 0) begin
                e.a = d;
                e.b = d;
            end else if (r == 1) begin
                e.a = hist[0][c];
                e.b = hist[0][c];
            end else begin
                e.a = hist[r-2][c];
                e.b = hist[r-1][c];
            end
`else
            e.v = (r >= 2);
            if (r >= 2) begin
                e.a = hist[r-2][c];
                e.b = hist[r-1][c];
            end else begin
                e.ka = 1'b0;
                e.kb = 1'b0;
            end
`endif
            hold = e;
            if (c == LL - 1) begin
                bcol = 0;
                if (brow < 15) brow++;
            end else begin
                bcol++;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("valid", 32'(dout_valid), 32'(g.v));
        chk("last", 32'(dout_last), 32'(g.last));
        if (g.ka) chk("doutA", 32'(doutA), 32'(g.a));
        if (g.kb) chk("doutB", 32'(doutB), 32'(g.b));
        chk("doutC", 32'(doutC), 32'(g.c));
        if (dout_valid === 1'b1) beats++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic frame(input logic [DW-1:0] base, input bit gaps);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < LL; c++) begin
                drive(1'b1, (r == 0 && c == 0), DW'(base + 16 * r + c));
                if (gaps) idle();
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_last"}, 32'(dout_last), 32'd0);
        chk({tag, "_A"}, 32'(doutA), 32'd0);
        chk({tag, "_B"}, 32'(doutB), 32'd0);
        chk({tag, "_C"}, 32'(doutC), 32'd0);
    endtask

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        check_zero("reset");
        arstn = 1'b1;
        idle();

        // continuous frame
        beats = 0;
        frame(8'h00, 1'b0);
        chk("beats_cont", 32'(beats), 32'(FRAME_BEATS));
        idle();

        // same frame with an idle cycle after every pixel
        beats = 0;
        frame(8'h00, 1'b1);
        chk("beats_gaps", 32'(beats), 32'(FRAME_BEATS));

        // sof in the middle of row 2
        beats = 0;
        for (int i = 0; i < 2 * LL + 2; i++)
            drive(1'b1, (i == 0), DW'(16 * (i / LL) + (i % LL)));
        beats = 0;
        drive(1'b1, 1'b1, 8'h77);
        for (int i = 1; i < 4 * LL; i++)
            drive(1'b1, 1'b0, DW'(8'h40 + 16 * (i / LL) + (i % LL)));
        chk("beats_midsof", 32'(beats), 32'(FRAME_BEATS));
        idle();

        // asynchronous reset during row 2
        for (int i = 0; i < 2 * LL + 2; i++)
            drive(1'b1, (i == 0), DW'(16 * (i / LL) + (i % LL)));
        #2;
        din_valid = 1'b0;
        arstn     = 1'b0;
        #1;
        check_zero("async_rst");
        clear_model();
        @(negedge clk);
        arstn = 1'b1;
        beats = 0;
        for (int i = 0; i < 4 * LL; i++)
            drive(1'b1, 1'b0, DW'(8'h50 + 16 * (i / LL) + (i % LL)));
        chk("beats_rst", 32'(beats), 32'(FRAME_BEATS));

        // back-to-back frames, no gap
        beats = 0;
        frame(8'h00, 1'b0);
        chk("beats_b2b_1", 32'(beats), 32'(FRAME_BEATS));
        beats = 0;
        frame(8'h80, 1'b0);
        chk("beats_b2b_2", 32'(beats), 32'(FRAME_BEATS));
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/line_window3.md
# line_window3

Three-row vertical window generator for the order-statistics filter datapath. It accepts a raster pixel stream one pixel per cycle and buffers the two previous lines internally. Each output beat is three vertically aligned pixels (rows y-2, y-1, y) at the same column. It is the producer that feeds the three-input sorter stage: its `doutA`/`doutB`/`doutC` drive the sorter's `dinA`/`dinB`/`dinC` directly.

## Interface
- `DATA_WIDTH`, 8: pixel width in bits.
- `LINE_LEN`, 640: pixels per line; fixed at elaboration, ≥2.
- `CNT_WIDTH`, 10: column counter width; must satisfy 2^CNT_WIDTH ≥ LINE_LEN.

Ports:
- `clk`  in  1  single clock, rising edge.
- `arstn`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  pixel present on `din` this cycle.
- `din`  in  DATA_WIDTH  input pixel, raster order.
- `sof`  in  1  start of frame; qualified by `din_valid`.
- `dout_valid`  out  1  window beat valid.
- `doutA`  out  DATA_WIDTH  pixel from row y-2.
- `doutB`  out  DATA_WIDTH  pixel from row y-1.
- `doutC`  out  DATA_WIDTH  pixel from row y (current).
- `dout_last`  out  1  beat is the last column of a line; only meaningful with `dout_valid`.

## Operation
- No backpressure. Every cycle with `din_valid`=1 accepts one pixel. The downstream sorter is a free-running pipeline.
- State:
  - `col` counter, 0..LINE_LEN-1.
  - `row` counter, saturating at 2.
  - Two line memories, `lb_a` and `lb_b`, each LINE_LEN×DATA_WIDTH.
- On an accepted pixel at column `col`, in one cycle:
  - Read `lb_a[col]` and `lb_b[col]` (old contents).
  - Write `lb_a[col]` ← old `lb_b[col]`, and `lb_b[col]` ← `din`. This is a cascade shift, so reads return pre-write data.
  - Register outputs: `doutA` ← old `lb_a[col]`, `doutB` ← old `lb_b[col]`, `doutC` ← `din`.
- Counter update:
  - `col` increments on each accepted pixel.
  - At `col`=LINE_LEN-1, `col` wraps to 0 and `row` increments, saturating at 2.
- `sof` with `din_valid`:
  - The pixel is treated as column 0 of row 0, i.e. `col`/`row` are forced to 0 before use and then advance normally.
  - Line memories are not cleared.
- `sof` without `din_valid` is ignored.
- `dout_valid` ← `din_valid` AND (effective row ≥ 2), in default configuration.
- `dout_last` ← accepted AND effective `col`=LINE_LEN-1.
- Idle cycles (`din_valid`=0):
  - Counters and memories hold.
  - `dout_valid`=0 and `dout_last`=0 on the next cycle.
  - `doutA/B/C` hold their last value.

## Timing
- Latency: 1 cycle from accepted `din` to the corresponding `dout*`.
- Throughput: 1 pixel/cycle sustained; arbitrary gaps are allowed.
- Reset values:
  - `dout_valid`=0, `dout_last`=0, `doutA`=`doutB`=`doutC`=0.
  - `col`=0, `row`=0.
  - Line memories are not reset; contents are undefined until written.
- Reset mid-line or mid-frame: the next accepted pixel is column 0, row 0, regardless of `sof`.
- Line wrap and `sof` in the same cycle: `sof` wins, giving row 0, col 0.
- LINE_LEN=2: `dout_last` asserts on every second accepted beat.
- Memories may be inferred as single-port RAM with read-before-write or as a register array. Either way, read-old-data semantics on the same address are required.

## Configuration
- `LINE_WINDOW3_BORDER_REPLICATE_EN` defined:
  - Top-border rows are emitted instead of suppressed, and `dout_valid` ← `din_valid` for every row.
  - Row 0: `doutA`=`doutB`=`doutC`=`din`.
  - Row 1: `doutA`=`doutB`= old `lb_b[col]` (row 0 pixel); `doutC`=`din`.
  - Row ≥2: as in the default configuration.
  - Result: the sorter sees the full image height.
- Not defined:
  - Rows 0 and 1 produce no valid beats.
  - Output frame height is H-2.

## Test plan
Common setup: LINE_LEN=4, DATA_WIDTH=8, pixel value = 16·row + col, `sof` on the first pixel.
1. Continuous frame of 4 rows, macro off:
   - No `dout_valid` during rows 0–1.
   - Row 2 col 1 gives, one cycle later, A=0x01, B=0x11, C=0x21.
   - Row 3 col 3 gives A=0x13, B=0x23, C=0x33 with `dout_last`=1.
   - Exactly 8 valid beats in total.
2. Same stream with `din_valid` toggling 1/0:
   - Identical valid-beat sequence.
   - `dout_valid` low after every idle cycle, and data held.
3. Macro on:
   - Row 0 col 2 gives A=B=C=0x02.
   - Row 1 col 2 gives A=B=0x02, C=0x12.
   - Exactly 16 valid beats in total.
4. Mid-frame `sof`: assert `sof` on row 2 col 2 with value 0x77.
   - No valid beats until two new lines are complete.
   - `dout_last` aligns to the new column 3.
5. `arstn` pulsed low during row 2:
   - All outputs read 0 immediately, asynchronously.
   - After release, the first pixel is treated as row 0, col 0, and no valid beats appear for 8 accepted pixels (macro off).
6. Back-to-back frames with `sof` and no gap:
   - Second frame row 2 output C matches the new data.
   - Beat count per frame is 8.
